// File: rtl/c3lib_tie_bank_lcell.sv
// WIDTH-bit bank of static tie-off values with a serial shadow-register override.
// The new pattern is loaded LSB-first, applied on commit, and revert returns the bank to TIE_VAL.
module c3lib_tie_bank_lcell #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] TIE_VAL = {WIDTH{1'b1}},
  parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_sin,
  input  logic             cfg_sin_vld,
  input  logic             cfg_commit,
  input  logic             cfg_revert,
  output logic [WIDTH-1:0] out,
  output logic             ovrd_active,
  output logic             shadow_full,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shadow, w_shadow_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_out, w_out_nxt;
  logic               r_ovrd, w_ovrd_nxt;
  logic               r_err, w_err_nxt;
  logic [WIDTH-1:0]   w_shift;

  // A one-bit bank has no upper bits to shift down, so the new bit simply replaces the shadow.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign w_shift = cfg_sin;
    end else begin : g_shift_multi
      assign w_shift = {cfg_sin, r_shadow[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: every signal gets a default before the case; a path that skips an assignment would infer a latch.
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_ovrd_nxt   = r_ovrd;
    w_err_nxt    = 1'b0;

    if (cfg_revert) begin
      // Revert outranks everything except reset and silently drops any commit or data bit.
      w_state_nxt  = ST_IDLE;
      w_shadow_nxt = TIE_VAL;
      w_cnt_nxt    = '0;
      w_out_nxt    = TIE_VAL;
      w_ovrd_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cfg_sin_vld) begin
            w_shadow_nxt = w_shift;
            w_cnt_nxt    = ONE_CNT;
            w_state_nxt  = (WIDTH == 1) ? ST_FULL : ST_SHIFT;
          end
          if (cfg_commit) w_err_nxt = 1'b1;
        end
        ST_SHIFT: begin
          if (cfg_sin_vld) begin
            w_shadow_nxt = w_shift;
            w_cnt_nxt    = r_cnt + ONE_CNT;
            if (r_cnt == LAST_CNT) w_state_nxt = ST_FULL;
          end
          if (cfg_commit) w_err_nxt = 1'b1;
        end
        ST_FULL: begin
          if (cfg_sin_vld) w_err_nxt = 1'b1;
          if (cfg_commit) begin
            // The shadow keeps the committed pattern; only the counter restarts.
            w_out_nxt   = r_shadow;
            w_ovrd_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shadow <= TIE_VAL;
      r_cnt    <= '0;
      r_out    <= TIE_VAL;
      r_ovrd   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      r_ovrd   <= w_ovrd_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign out         = r_out;
  assign ovrd_active = r_ovrd;
  assign shadow_full = (r_state == ST_FULL);
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_c3lib_tie_bank_lcell.sv
// Directed bench for c3lib_tie_bank_lcell: an 8-bit 8'hFF build and a 1-bit tie-low build.
// Inputs change 1 ns after the rising edge, and outputs are sampled at that same point.
module tb_c3lib_tie_bank_lcell;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin, vld, cm, rv;
  logic [7:0] out;
  logic       ovrd, full, err;
  logic       sin1, vld1, cm1, rv1;
  logic [0:0] out1;
  logic       ovrd1, full1, err1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  c3lib_tie_bank_lcell #(.WIDTH(8), .TIE_VAL(8'hFF)) dut8 (
    .clk(clk), .rst(rst), .cfg_sin(sin), .cfg_sin_vld(vld), .cfg_commit(cm),
    .cfg_revert(rv), .out(out), .ovrd_active(ovrd), .shadow_full(full), .cfg_err(err)
  );

  c3lib_tie_bank_lcell #(.WIDTH(1), .TIE_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .cfg_sin(sin1), .cfg_sin_vld(vld1), .cfg_commit(cm1),
    .cfg_revert(rv1), .out(out1), .ovrd_active(ovrd1), .shadow_full(full1), .cfg_err(err1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One clock of stimulus on the 8-bit build; all strobes drop afterwards.
  task automatic tick(input logic i_sin, input logic i_vld, input logic i_cm, input logic i_rv);
    sin = i_sin; vld = i_vld; cm = i_cm; rv = i_rv;
    @(posedge clk); #1;
    sin = 1'b0; vld = 1'b0; cm = 1'b0; rv = 1'b0;
  endtask

  task automatic tick1(input logic i_sin, input logic i_vld, input logic i_cm, input logic i_rv);
    sin1 = i_sin; vld1 = i_vld; cm1 = i_cm; rv1 = i_rv;
    @(posedge clk); #1;
    sin1 = 1'b0; vld1 = 1'b0; cm1 = 1'b0; rv1 = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    sin = 1'b0; vld = 1'b0; cm = 1'b0; rv = 1'b0;
    sin1 = 1'b0; vld1 = 1'b0; cm1 = 1'b0; rv1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset values
    check("rst_out", out, 8'hFF);
    check_bit("rst_ovrd", ovrd, 1'b0);
    check_bit("rst_full", full, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check("rst_out1", {7'b0, out1}, 8'h00);

    // Load 8'hA5 LSB-first, then commit
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick(pat[i], 1'b1, 1'b0, 1'b0);
      check_bit($sformatf("a5_full_%0d", i), full, (i == 7));
    end
    check("a5_out_pre_commit", out, 8'hFF);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_out", out, 8'hA5);
    check_bit("a5_ovrd", ovrd, 1'b1);
    check_bit("a5_full_after", full, 1'b0);
    check_bit("a5_err", err, 1'b0);

    // Commit after 5 bits of 8'h5A is a violation
    pat = 8'h5A;
    for (int i = 0; i < 5; i++) tick(pat[i], 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("early_commit_err", err, 1'b1);
    check("early_commit_out", out, 8'hA5);
    check_bit("early_commit_full", full, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("early_commit_err_drop", err, 1'b0);
    for (int i = 5; i < 8; i++) tick(pat[i], 1'b1, 1'b0, 1'b0);
    check_bit("5a_full", full, 1'b1);

    // Ninth bit in FULL is discarded and flagged
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("ninth_err", err, 1'b1);
    check_bit("ninth_full", full, 1'b1);

    // Commit with a simultaneous bit: commit applied, bit dropped, error flagged
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("cv_out", out, 8'h5A);
    check_bit("cv_err", err, 1'b1);
    check_bit("cv_full", full, 1'b0);
    check_bit("cv_ovrd", ovrd, 1'b1);

    // Back-to-back violations keep cfg_err high continuously
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("b2b_err_0", err, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("b2b_err_1", err, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("b2b_err_end", err, 1'b0);

    // Reload 8'hA5, then revert together with commit while FULL
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) tick(pat[i], 1'b1, 1'b0, 1'b0);
    check_bit("rv_pre_full", full, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check("rv_out", out, 8'hFF);
    check_bit("rv_ovrd", ovrd, 1'b0);
    check_bit("rv_err", err, 1'b0);
    check_bit("rv_full", full, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("rv_then_commit_err", err, 1'b1);
    check("rv_then_commit_out", out, 8'hFF);

    // Revert after 3 bits clears the count; 8'h3C then loads with vld gaps
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    check_bit("rv_mid_err", err, 1'b0);
    check_bit("rv_mid_full", full, 1'b0);
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      tick(pat[i], 1'b1, 1'b0, 1'b0);
      if (i == 6) check_bit("3c_full_at_7", full, 1'b0);
      if (i % 2 == 1 && i != 7) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_bit("3c_full", full, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("3c_out", out, 8'h3C);
    check_bit("3c_ovrd", ovrd, 1'b1);

    // Reset mid-shift while overridden
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst2_out", out, 8'hFF);
    check_bit("rst2_ovrd", ovrd, 1'b0);
    check_bit("rst2_full", full, 1'b0);
    check_bit("rst2_err", err, 1'b0);
    pat = 8'h81;
    for (int i = 0; i < 8; i++) begin
      tick(pat[i], 1'b1, 1'b0, 1'b0);
      if (i == 6) check_bit("81_full_at_7", full, 1'b0);
    end
    check_bit("81_full", full, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("81_out", out, 8'h81);

    // One-bit tie-low build
    tick1(1'b1, 1'b1, 1'b0, 1'b0);
    check_bit("w1_full", full1, 1'b1);
    check_bit("w1_out_pre", out1[0], 1'b0);
    tick1(1'b0, 1'b0, 1'b1, 1'b0);
    check_bit("w1_out", out1[0], 1'b1);
    check_bit("w1_ovrd", ovrd1, 1'b1);
    check_bit("w1_full_after", full1, 1'b0);
    tick1(1'b0, 1'b0, 1'b0, 1'b1);
    check_bit("w1_rv_out", out1[0], 1'b0);
    check_bit("w1_rv_ovrd", ovrd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
